// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: opcodes (also used by the control decoder),
// symbolic instruction kinds accepted by the program loader, and loader error codes.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  typedef enum logic [3:0] {
    K_R     = 4'd0,
    K_LW    = 4'd1,
    K_SW    = 4'd2,
    K_BEQ   = 4'd3,
    K_BNE   = 4'd4,
    K_ADDI  = 4'd5,
    K_ADDIU = 4'd6,
    K_ANDI  = 4'd7,
    K_ORI   = 4'd8,
    K_XORI  = 4'd9,
    K_LUI   = 4'd10,
    K_J     = 4'd11,
    K_JAL   = 4'd12
  } kind_e;

  typedef enum logic [2:0] {
    ERR_NONE   = 3'd0,
    ERR_KIND   = 3'd1,
    ERR_BRANCH = 3'd2,
    ERR_JUMP   = 3'd3,
    ERR_OVF    = 3'd4
  } err_e;

  // Primary opcode for a given instruction kind (illegal kinds map to 0).
  function automatic logic [5:0] kind_opcode(input logic [3:0] kind);
    logic [5:0] op;
    op = OP_RTYPE;
    case (kind)
      K_LW:    op = OP_LW;
      K_SW:    op = OP_SW;
      K_BEQ:   op = OP_BEQ;
      K_BNE:   op = OP_BNE;
      K_ADDI:  op = OP_ADDI;
      K_ADDIU: op = OP_ADDIU;
      K_ANDI:  op = OP_ANDI;
      K_ORI:   op = OP_ORI;
      K_XORI:  op = OP_XORI;
      K_LUI:   op = OP_LUI;
      K_J:     op = OP_J;
      K_JAL:   op = OP_JAL;
      default: op = OP_RTYPE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: symbolic instruction kind + fields + pc -> 32-bit
// machine word, with target range/alignment checking for branches and jumps.
module instr_field_packer
  import mips_isa_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [31:0] target,
  input  logic [31:0] pc,
  output logic [31:0] word,
  output logic [2:0]  err
);

  logic [31:0]        pc4;
  logic signed [31:0] diff;
  logic signed [31:0] off;
  logic               br_ok;
  logic               jmp_ok;
  logic [5:0]         op;

  assign pc4    = pc + 32'd4;
  assign diff   = $signed(target - pc4);
  assign off    = diff >>> 2;
  assign br_ok  = (target[1:0] == 2'b00) && (off >= -32'sd32768) && (off <= 32'sd32767);
  assign jmp_ok = (target[1:0] == 2'b00) && (target[31:28] == pc4[31:28]);
  assign op     = kind_opcode(kind);

  // Select the instruction format and flag targets that cannot be encoded.
  always_comb begin
    word = '0;
    err  = ERR_NONE;
    case (kind)
      K_R: word = {OP_RTYPE, rs, rt, rd, shamt, funct};
      K_LW, K_SW, K_ADDI, K_ADDIU, K_ANDI, K_ORI, K_XORI:
        word = {op, rs, rt, imm};
      K_LUI: word = {op, 5'd0, rt, imm};
      K_BEQ, K_BNE: begin
        word = {op, rs, rt, off[15:0]};
        if (!br_ok) err = ERR_BRANCH;
      end
      K_J, K_JAL: begin
        word = {op, target[27:2]};
        if (!jmp_ok) err = ERR_JUMP;
      end
      default: err = ERR_KIND;
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Program loader: accepts symbolic instructions over valid/ready, encodes
// them and writes them sequentially into instruction memory from base_addr.
module instr_stream_encoder
  import mips_isa_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_kind,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_shamt,
  input  logic [5:0]       in_funct,
  input  logic [15:0]      in_imm,
  input  logic [31:0]      in_target,
  input  logic             done_req,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [2:0]       err_code
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_e;

  state_e           state, state_nxt;
  logic [31:0]      base;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       err_q;
  logic [31:0]      pc;
  logic [31:0]      pk_word;
  logic [2:0]       pk_err;
  logic [2:0]       beat_code;
  logic             acc;
  logic             beat_bad;
  logic             wr;

  assign pc        = base + {{(30-CNT_W){1'b0}}, cnt, 2'b00};
  assign acc       = in_valid & in_ready;
  assign beat_code = (cnt == CNT_W'(DEPTH)) ? ERR_OVF : pk_err;
  assign beat_bad  = (beat_code != ERR_NONE);
  assign wr        = acc & ~beat_bad;

  instr_field_packer u_packer (
    .kind   (in_kind),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .shamt  (in_shamt),
    .funct  (in_funct),
    .imm    (in_imm),
    .target (in_target),
    .pc     (pc),
    .word   (pk_word),
    .err    (pk_err)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state: start overrides everything; a bad beat beats done_req.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = S_LOAD;
    end else if (state == S_LOAD) begin
      if (acc && beat_bad) state_nxt = S_ERR;
      else if (done_req)   state_nxt = S_DONE;
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    in_ready = (state == S_LOAD) && !start;
    busy     = (state == S_LOAD);
    done     = (state == S_DONE);
    error    = (state == S_ERR);
  end

  // Session registers: base, word count, latched error code.
  always_ff @(posedge clk) begin
    if (reset) begin
      base  <= '0;
      cnt   <= '0;
      err_q <= ERR_NONE;
    end else if (start) begin
      base  <= base_addr;
      cnt   <= '0;
      err_q <= ERR_NONE;
    end else if (acc) begin
      if (beat_bad) err_q <= beat_code;
      else          cnt   <= cnt + CNT_W'(1);
    end
  end

  // Output stage: one registered write per accepted legal beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= wr;
      if (wr) begin
        imem_addr  <= pc;
        imem_wdata <= pk_word;
      end
    end
  end

  assign count    = cnt;
  assign err_code = err_q;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Bench for instr_stream_encoder: directed scenarios plus randomized sessions,
// all checked against an arithmetic reference model of the loader.
module tb_instr_stream_encoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 11;

  logic             clk = 1'b0;
  logic             reset, start, in_valid, done_req;
  logic [31:0]      base_addr, in_target;
  logic [3:0]       in_kind;
  logic [4:0]       in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]       in_funct;
  logic [15:0]      in_imm;
  logic             in_ready, imem_we, busy, done, error;
  logic [31:0]      imem_addr, imem_wdata;
  logic [CNT_W-1:0] count;
  logic [2:0]       err_code;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: 0 idle, 1 load, 2 done, 3 err
  int          m_state = 0;
  logic [31:0] m_base  = 0;
  logic [31:0] m_addr  = 0;
  logic [31:0] m_wdata = 0;
  int          m_count = 0;
  int          m_err   = 0;

  always #5 clk = ~clk;

  instr_stream_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .done_req(done_req), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .count(count), .busy(busy), .done(done),
    .error(error), .err_code(err_code)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference encoder built from the field layout with plain arithmetic.
  function automatic void ref_encode(input int kind, input logic [31:0] rs, rt, rd, sh, fn, im,
                                     input logic [31:0] tg, pc,
                                     output logic [31:0] w, output int e);
    logic [31:0] optab [13];
    logic [31:0] op;
    int d;
    optab = '{32'd0, 32'd35, 32'd43, 32'd4, 32'd5, 32'd8, 32'd9, 32'd12, 32'd13, 32'd14, 32'd15, 32'd2, 32'd3};
    w = 0;
    e = 0;
    if (kind >= 13) begin
      e = 1;
    end else begin
      op = optab[kind];
      if (kind == 0) begin
        w = rs * 32'd2097152 + rt * 32'd65536 + rd * 32'd2048 + sh * 32'd64 + fn;
      end else if (kind == 3 || kind == 4) begin
        d = $signed(tg - pc - 32'd4);
        if (tg % 4 != 0) e = 2;
        else begin
          d = d / 4;
          if (d < -32768 || d > 32767) e = 2;
          else w = op * 32'd67108864 + rs * 32'd2097152 + rt * 32'd65536 + (32'(d) & 32'hFFFF);
        end
      end else if (kind >= 11) begin
        if (tg % 4 != 0) e = 3;
        else if ((tg / 32'h10000000) != ((pc + 32'd4) / 32'h10000000)) e = 3;
        else w = op * 32'd67108864 + ((tg / 4) % 32'h04000000);
      end else begin
        w = op * 32'd67108864 + ((kind == 10) ? 32'd0 : rs * 32'd2097152) + rt * 32'd65536 + im;
      end
    end
  endfunction

  // One clock cycle: check ready, advance the model, check registered outputs.
  task automatic step();
    logic        exp_rdy, exp_we;
    logic [31:0] pc, w;
    int          e;
    #1;
    exp_rdy = (m_state == 1) && !start;
    if (!reset) check("in_ready", in_ready, exp_rdy);
    exp_we = 1'b0;
    if (reset) begin
      m_state = 0; m_base = 0; m_count = 0; m_err = 0; m_addr = 0; m_wdata = 0;
    end else if (start) begin
      m_state = 1; m_base = base_addr; m_count = 0; m_err = 0;
    end else if (m_state == 1) begin
      if (in_valid) begin
        pc = m_base + 32'(m_count * 4);
        if (m_count == DEPTH) begin
          w = 0; e = 4;
        end else begin
          ref_encode(int'(in_kind), 32'(in_rs), 32'(in_rt), 32'(in_rd), 32'(in_shamt),
                     32'(in_funct), 32'(in_imm), in_target, pc, w, e);
        end
        if (e != 0) begin
          m_state = 3; m_err = e;
        end else begin
          exp_we = 1'b1; m_addr = pc; m_wdata = w; m_count++;
          if (done_req) m_state = 2;
        end
      end else if (done_req) begin
        m_state = 2;
      end
    end
    @(posedge clk);
    #1;
    check("imem_we", imem_we, exp_we);
    check("imem_addr", imem_addr, m_addr);
    check("imem_wdata", imem_wdata, m_wdata);
    check("count", 32'(count), 32'(m_count));
    check("busy", busy, m_state == 1);
    check("done", done, m_state == 2);
    check("error", error, m_state == 3);
    check("err_code", err_code, 32'(m_err));
  endtask

  task automatic set_beat(input logic [3:0] k, input logic [4:0] rs, rt, rd, sh,
                          input logic [5:0] fn, input logic [15:0] im, input logic [31:0] tg);
    in_valid = 1'b1; in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_funct = fn; in_imm = im; in_target = tg;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; start = 1'b0; done_req = 1'b0; reset = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] b);
    idle_in();
    start = 1'b1; base_addr = b;
    step();
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] pcg, tg;
    int r;
    idle_in();
    base_addr = 0;
    set_beat(0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("rst_ready", in_ready, 1'b0);

    // addi then R-type from 0x00400000
    do_start(32'h00400000);
    set_beat(4'd5, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 32'd0);
    step();
    check("t1_wdata", imem_wdata, 32'h20080005);
    check("t1_addr", imem_addr, 32'h00400000);
    set_beat(4'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'd0, 32'd0);
    step();
    check("t2_wdata", imem_wdata, 32'h01095020);
    check("t2_count", 32'(count), 32'd2);
    // backward beq, then an out-of-range beq
    set_beat(4'd3, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 16'd0, 32'h00400000);
    step();
    check("t3_wdata", imem_wdata, 32'h1109FFFD);
    set_beat(4'd3, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 16'd0, 32'h00500000);
    step();
    check("t3_err", err_code, 32'd2);
    step();
    in_valid = 1'b0;

    // jumps
    do_start(32'h00400000);
    set_beat(4'd11, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 32'h00400000);
    step();
    check("t4_j", imem_wdata, 32'h08100000);
    do_start(32'h00400000);
    set_beat(4'd12, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 32'h10000000);
    step();
    check("t4_jal_err", err_code, 32'd3);

    // illegal kind, then start clears the error
    do_start(32'h00001000);
    set_beat(4'd14, 5'd1, 5'd2, 5'd3, 5'd0, 6'd0, 16'd0, 32'd0);
    step();
    check("t5_err", err_code, 32'd1);
    step();
    step();
    do_start(32'h00002000);
    check("t5_clr", 32'(error), 32'd0);

    // overflow at DEPTH beats
    for (int i = 0; i < 5; i++) begin
      set_beat(4'd8, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'(i), 32'd0);
      step();
    end
    check("t6_ovf", err_code, 32'd4);
    check("t6_cnt", 32'(count), 32'd4);
    in_valid = 1'b0;

    // done_req together with the third beat
    do_start(32'h00003000);
    for (int i = 0; i < 3; i++) begin
      set_beat(4'd10, 5'd7, 5'd3, 5'd0, 5'd0, 6'd0, 16'hABCD, 32'd0);
      done_req = (i == 2);
      step();
    end
    check("t6_done", 32'(done), 32'd1);
    check("t6_lui", imem_wdata, 32'h3C03ABCD);
    step();
    done_req = 1'b0;
    in_valid = 1'b0;
    step();

    // start mid-load: pending write still appears, count restarts
    do_start(32'h00004000);
    set_beat(4'd1, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'h0010, 32'd0);
    step();
    start = 1'b1; base_addr = 32'h00005000;
    step();
    start = 1'b0;
    // reset mid-load: pending write is dropped
    set_beat(4'd2, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'h0020, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    step();

    // randomized sessions
    for (int s = 0; s < 150; s++) begin
      r = $urandom_range(0, 3);
      case (r)
        0: do_start(32'h00400000);
        1: do_start(32'h0FFFFFF8);
        2: do_start(32'h0FFFFFF0);
        default: do_start({$urandom_range(0, 32'h3FFFFFFF), 2'b00});
      endcase
      for (int c = 0; c < 10; c++) begin
        pcg = m_base + 32'(m_count * 4);
        case ($urandom_range(0, 5))
          0: tg = pcg + 32'd4 + 32'($signed($urandom_range(0, 400)) - 200) * 32'd4;
          1: tg = pcg + 32'd4 + 32'd131068;
          2: tg = pcg + 32'd4 + 32'd131072;
          3: tg = pcg + 32'd4 - (($urandom_range(0, 1) == 1) ? 32'd131072 : 32'd131076);
          4: tg = pcg + 32'd1 + 32'($urandom_range(0, 2));
          default: tg = $urandom;
        endcase
        set_beat(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom),
                 5'($urandom), 6'($urandom), 16'($urandom), tg);
        in_valid = ($urandom_range(0, 3) != 0);
        done_req = ($urandom_range(0, 11) == 0);
        start    = ($urandom_range(0, 29) == 0);
        base_addr = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
        reset    = ($urandom_range(0, 99) == 0);
        step();
      end
      idle_in();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
